// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        REPORT  = 2'd3
    } sweep_state_e;

    function automatic int table_size(input int n_inputs);
        return 2 ** n_inputs;
    endfunction

    // Expected truth tables for the 3-input SOP gate variants, bit i = F(minterm i).
    localparam logic [7:0] EXP_SOP3       = 8'h13;  // F = ~B & (~A | ~C)
    localparam logic [7:0] EXP_SOP3_NOT_B = 8'h33;  // F = ~B
    localparam logic [7:0] EXP_SOP3_ZERO  = 8'h00;  // constant 0

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter; tc flags that the settle interval has elapsed.
module settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every minterm onto a small gate, captures its output and scores it
// against an expected truth table.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                        N_INPUTS      = 3,
    parameter int                        SETTLE_CYCLES = 1,
    parameter logic [2**N_INPUTS-1:0]    EXPECTED      = EXP_SOP3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    output logic [N_INPUTS-1:0]       VEC,
    input  logic                      F_IN,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      PASS,
    output logic [2**N_INPUTS-1:0]    MINTERMS,
    output logic [N_INPUTS:0]         ERR_COUNT,
    output logic [N_INPUTS-1:0]       FIRST_ERR
);

    localparam int TABLE_SIZE = table_size(N_INPUTS);
    localparam logic [N_INPUTS-1:0] IDX_LAST = N_INPUTS'(TABLE_SIZE - 1);
    localparam logic [N_INPUTS-1:0] IDX_ONE  = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]   ERR_ONE  = (N_INPUTS + 1)'(1);

    sweep_state_e            state_q, state_d;
    logic [N_INPUTS-1:0]     idx_q;
    logic [TABLE_SIZE-1:0]   minterms_q;
    logic [N_INPUTS:0]       err_q;
    logic [N_INPUTS-1:0]     first_q;
    logic                    pass_q;

    logic accept, last, mismatch, tc, timer_load;

    assign accept   = (state_q == IDLE) && START;
    assign last     = (idx_q == IDX_LAST);
    assign mismatch = (F_IN != EXPECTED[idx_q]);

    assign timer_load = accept || (state_q == CAPTURE && !last);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (CLK),
        .rst  (RST),
        .load (timer_load),
        .en   (state_q == APPLY),
        .tc   (tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (START) state_d = APPLY;
            APPLY:   if (tc) state_d = CAPTURE;
            CAPTURE: state_d = last ? REPORT : APPLY;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q      <= '0;
            minterms_q <= '0;
            err_q      <= '0;
            first_q    <= '0;
            pass_q     <= 1'b0;
        end else if (accept) begin
            idx_q      <= '0;
            minterms_q <= '0;
            err_q      <= '0;
            first_q    <= '0;
            pass_q     <= 1'b0;
        end else if (state_q == CAPTURE) begin
            minterms_q[idx_q] <= F_IN;
            if (mismatch) begin
                err_q <= err_q + ERR_ONE;
                if (err_q == '0) first_q <= idx_q;
            end
            // PASS must fold in the verdict of the final vector captured this edge.
            if (last) begin
                pass_q <= (err_q == '0) && !mismatch;
            end else begin
                idx_q <= idx_q + IDX_ONE;
            end
        end
    end

    assign VEC       = (state_q == APPLY || state_q == CAPTURE) ? idx_q : '0;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = (state_q == REPORT);
    assign PASS      = pass_q;
    assign MINTERMS  = minterms_q;
    assign ERR_COUNT = err_q;
    assign FIRST_ERR = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: table-driven sweeps on the default controller plus hand
// sequences for reset abort, ignored STARTs and back-to-back sweeps.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT 0: defaults (SETTLE_CYCLES = 1)
    logic       rst0, start0, f0;
    logic [2:0] vec0, first0;
    logic       busy0, done0, pass0;
    logic [7:0] mint0;
    logic [3:0] err0;
    int         gate_sel;

    // DUT 1: SETTLE_CYCLES = 3, always driven by the correct gate
    logic       rst1, start1, f1;
    logic [2:0] vec1, first1;
    logic       busy1, done1, pass1;
    logic [7:0] mint1;
    logic [3:0] err1;

    truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(1), .EXPECTED(8'h13)) dut0 (
        .CLK(clk), .RST(rst0), .START(start0), .VEC(vec0), .F_IN(f0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .MINTERMS(mint0),
        .ERR_COUNT(err0), .FIRST_ERR(first0)
    );

    truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(3), .EXPECTED(8'h13)) dut1 (
        .CLK(clk), .RST(rst1), .START(start1), .VEC(vec1), .F_IN(f1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .MINTERMS(mint1),
        .ERR_COUNT(err1), .FIRST_ERR(first1)
    );

    // Gate models: A = VEC[2], B = VEC[1], C = VEC[0]
    always_comb begin
        case (gate_sel)
            0:       f0 = ~vec0[1] & (~vec0[2] | ~vec0[0]);
            1:       f0 = ~vec0[1];
            default: f0 = 1'b0;
        endcase
    end
    assign f1 = ~vec1[1] & (~vec1[2] | ~vec1[0]);

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int gate;
        int exp_mint;
        int exp_pass;
        int exp_err;
        int exp_first;
    } vec_t;

    vec_t tbl [3];

    task automatic reset0();
        @(negedge clk);
        rst0 = 1'b1; start0 = 1'b0;
        @(negedge clk);
        rst0 = 1'b0;
    endtask

    initial begin
        int done_at, n_done, d1_cnt;
        int d1_at [2];
        logic [7:0] m_at_done;
        logic [3:0] e_at_done;
        logic [2:0] f_at_done;
        logic       p_at_done;

        tbl[0] = '{gate: 0, exp_mint: 'h13, exp_pass: 1, exp_err: 0, exp_first: 0};
        tbl[1] = '{gate: 1, exp_mint: 'h33, exp_pass: 0, exp_err: 1, exp_first: 5};
        tbl[2] = '{gate: 2, exp_mint: 'h00, exp_pass: 0, exp_err: 3, exp_first: 0};

        gate_sel = 0;
        rst0 = 1'b1; start0 = 1'b0;
        rst1 = 1'b1; start1 = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        check("rst_vec",   vec0,   0);
        check("rst_busy",  busy0,  0);
        check("rst_done",  done0,  0);
        check("rst_pass",  pass0,  0);
        check("rst_mint",  mint0,  0);
        check("rst_err",   err0,   0);
        check("rst_first", first0, 0);

        // Table-driven full sweeps on DUT 0
        foreach (tbl[i]) begin
            reset0();
            gate_sel = tbl[i].gate;
            start0 = 1'b1;                       // cycle t
            done_at = 0; n_done = 0;
            m_at_done = '0; e_at_done = '0; f_at_done = '0; p_at_done = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);                  // cycle t+k
                start0 = 1'b0;
                if (i == 0 && k <= 16) begin
                    check($sformatf("vec_k%0d", k), vec0, (k - 1) / 2);
                    check($sformatf("busy_k%0d", k), busy0, 1);
                end
                if (done0) begin
                    n_done++;
                    if (done_at == 0) begin
                        done_at = k;
                        m_at_done = mint0; e_at_done = err0;
                        f_at_done = first0; p_at_done = pass0;
                    end
                end
            end
            check($sformatf("t%0d_done_cycle", i), done_at, 17);
            check($sformatf("t%0d_done_count", i), n_done, 1);
            check($sformatf("t%0d_mint", i),  m_at_done, tbl[i].exp_mint);
            check($sformatf("t%0d_err", i),   e_at_done, tbl[i].exp_err);
            check($sformatf("t%0d_first", i), f_at_done, tbl[i].exp_first);
            check($sformatf("t%0d_pass", i),  p_at_done, tbl[i].exp_pass);
            check($sformatf("t%0d_hold_mint", i), mint0, tbl[i].exp_mint);
            check($sformatf("t%0d_hold_pass", i), pass0, tbl[i].exp_pass);
            check($sformatf("t%0d_idle_busy", i), busy0, 0);
        end

        // New START clears PASS left over from a passing sweep
        reset0();
        gate_sel = 0;
        start0 = 1'b1;
        for (int k = 1; k <= 18; k++) begin @(negedge clk); start0 = 1'b0; end
        check("pre_pass", pass0, 1);
        start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        check("clr_pass", pass0, 0);
        check("clr_mint", mint0, 0);

        // Reset mid-sweep at t+7
        reset0();
        gate_sel = 0;
        start0 = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (k == 7) begin
                check("pre_rst_mint", mint0, 'h03);
                rst0 = 1'b1;
            end
            if (k == 8) rst0 = 1'b0;
        end
        check("abort_busy", busy0, 0);
        check("abort_vec",  vec0,  0);
        check("abort_mint", mint0, 0);
        check("abort_err",  err0,  0);
        check("abort_pass", pass0, 0);
        for (int k = 9; k <= 28; k++) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // RST and START in the same cycle: reset wins
        @(negedge clk);
        rst0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0; start0 = 1'b0;
        check("rst_start_busy", busy0, 0);
        @(negedge clk);
        check("rst_start_busy2", busy0, 0);

        // Extra START pulses at t+3 and in the REPORT cycle are ignored
        reset0();
        gate_sel = 0;
        start0 = 1'b1;
        done_at = 0; n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start0 = (k == 3 || k == 17);
            if (done0) begin
                n_done++;
                if (done_at == 0) done_at = k;
            end
        end
        check("extra_done_cycle", done_at, 17);
        check("extra_done_count", n_done, 1);
        check("extra_mint", mint0, 'h13);
        check("extra_pass", pass0, 1);
        check("extra_err",  err0,  0);

        // SETTLE_CYCLES = 3 with START held high on DUT 1
        start1 = 1'b1;
        d1_cnt = 0; d1_at[0] = 0; d1_at[1] = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 2) check("s3_vec_hold", vec1, 0);
            if (k == 4) check("s3_vec_step", vec1, 0);
            if (k == 5) check("s3_vec_next", vec1, 1);
            if (done1) begin
                if (d1_cnt < 2) begin
                    d1_at[d1_cnt] = k;
                    check($sformatf("s3_mint_%0d", d1_cnt), mint1, 'h13);
                    check($sformatf("s3_pass_%0d", d1_cnt), pass1, 1);
                    check($sformatf("s3_err_%0d", d1_cnt),  err1,  0);
                end
                d1_cnt++;
            end
            if (k == 34) check("s3_idle_gap", busy1, 0);
            if (k == 35) check("s3_reaccept", busy1, 1);
        end
        start1 = 1'b0;
        check("s3_done1_cycle", d1_at[0], 33);
        check("s3_done2_cycle", d1_at[1], 67);
        check("s3_done_count",  d1_cnt,   2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencing controller for small combinational gate blocks such as the 3-input SOP gates. It drives every input combination onto the gate in ascending minterm order and waits a programmable settle time per vector. It captures the gate output into a minterm vector and compares that vector against an expected truth table. It sits between a bench or self-test sequencer and the gate under control, and reports pass/fail, mismatch count and first failing minterm.

## Interface
- N_INPUTS, default 3: number of gate inputs; table size is 2^N_INPUTS.
- SETTLE_CYCLES, default 1: cycles each vector is held before capture; must be ≥1.
- EXPECTED, default 8'h13: expected truth table, bit i = F for minterm i (8'h13 = minterms 0,1,4).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  begin a sweep; sampled only in IDLE.
- VEC  output  N_INPUTS  drive to gate inputs; MSB = A, LSB = C for N_INPUTS=3.
- F_IN  input  1  gate output.
- BUSY  output  1  high from the cycle after START acceptance until REPORT inclusive.
- DONE  output  1  one-cycle pulse in REPORT.
- PASS  output  1  MINTERMS == EXPECTED; valid from DONE until the next accepted START.
- MINTERMS  output  2^N_INPUTS  captured truth table.
- ERR_COUNT  output  N_INPUTS+1  number of mismatching minterms.
- FIRST_ERR  output  N_INPUTS  lowest mismatching minterm index; 0 when ERR_COUNT = 0.

## Operation
- States: IDLE, APPLY, CAPTURE, REPORT.
- IDLE: VEC = 0. START=1 → APPLY. On entry to APPLY: idx = 0, settle counter = 0, and MINTERMS, ERR_COUNT, FIRST_ERR and PASS cleared.
- APPLY: VEC = idx. Counter increments each cycle. At count SETTLE_CYCLES-1 → CAPTURE.
- CAPTURE: VEC = idx. At the edge:
  - MINTERMS[idx] ← F_IN.
  - On mismatch (F_IN ≠ EXPECTED[idx]): ERR_COUNT += 1. If this is the first mismatch, FIRST_ERR ← idx.
  - If idx = 2^N_INPUTS-1 → REPORT. Otherwise idx += 1, counter = 0, → APPLY.
- REPORT: VEC = 0, DONE = 1, BUSY = 1, PASS = (ERR_COUNT == 0). PASS is registered on entry. Next state is IDLE unconditionally.
- START in APPLY, CAPTURE or REPORT is ignored and does not queue.
- START held high continuously: a new sweep is accepted in the IDLE cycle after each REPORT.
- idx does not wrap. The terminal compare in CAPTURE is the only exit from the sweep.
- ERR_COUNT saturation is never needed; its width covers the full 2^N_INPUTS count.
- RST at any cycle, including mid-sweep:
  - Next state IDLE.
  - All outputs 0: VEC, BUSY, DONE, PASS, MINTERMS, ERR_COUNT, FIRST_ERR.
  - No DONE pulse is produced for the aborted sweep.
- RST and START in the same cycle: RST wins.

## Timing
- Reset values: all outputs 0; state IDLE.
- START sampled high at cycle t (IDLE). VEC = 0 is driven from t+1.
- Each vector is held SETTLE_CYCLES+1 cycles; F_IN is sampled at the end of the last of those cycles.
- DONE is high in cycle t + 2^N_INPUTS·(SETTLE_CYCLES+1) + 1. For defaults: t+17.
- MINTERMS, ERR_COUNT and FIRST_ERR are stable in the DONE cycle and hold until the next accepted START.
- F_IN is treated as combinational from VEC. No combinational path exists from F_IN to any output.

## Structure
- Package sweep_pkg holds:
  - the state enum (IDLE, APPLY, CAPTURE, REPORT);
  - the localparam TABLE_SIZE = 2**N_INPUTS helper function;
  - the default EXPECTED constant for each gate variant.
- One sub-module: settle_timer. It is a loadable down-counter with a terminal-count flag, parameterized by SETTLE_CYCLES.
- The gate under control is instantiated outside this block, in the bench or system top.

## Test plan
- Correct gate F = ~B & (~A | ~C), defaults, START pulse at t → DONE at t+17, MINTERMS = 8'h13, PASS = 1, ERR_COUNT = 0, FIRST_ERR = 0. VEC steps 0..7, each held 2 cycles.
- Faulty gate F = ~B → MINTERMS = 8'h33, PASS = 0, ERR_COUNT = 1, FIRST_ERR = 5.
- Stuck-at-0 gate → MINTERMS = 8'h00, ERR_COUNT = 3, FIRST_ERR = 0, PASS = 0.
- RST at t+7 mid-sweep → at t+8 BUSY = 0, VEC = 0, MINTERMS = 0. No DONE in the following 20 cycles.
- Extra START pulses at t+3 and at the REPORT cycle → exactly one DONE, at t+17, and the results are unchanged.
- SETTLE_CYCLES = 3 with START held high → first DONE at t+33, second sweep accepted at t+34, second DONE at t+67 with identical results.
